// File: rtl/exe_stage_pkg.sv
// Shared execute-stage encodings: ALU command codes, shift types and status
// register bit positions, common to decode and execute.
package exe_stage_pkg;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    // Status register layout is {N,Z,C,V}
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
    import exe_stage_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    logic [4:0]  rot_amt_s;
    logic [4:0]  sh_amt_s;
    logic [63:0] imm_rot_s;
    logic [63:0] rm_rot_s;

    // Rotations are taken from the low half of a doubled word shifted right
    assign rot_amt_s = {shift_operand[11:8], 1'b0};
    assign sh_amt_s  = shift_operand[11:7];
    assign imm_rot_s = {24'd0, shift_operand[7:0], 24'd0, shift_operand[7:0]} >> rot_amt_s;
    assign rm_rot_s  = {val_rm, val_rm} >> sh_amt_s;

    // Operand select and barrel shift
    always_comb begin
        val2 = val_rm;
        if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = imm_rot_s[31:0];
        end else begin
            case (shift_type_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = val_rm << sh_amt_s;
                SHIFT_LSR: val2 = val_rm >> sh_amt_s;
                SHIFT_ASR: val2 = $unsigned($signed(val_rm) >>> sh_amt_s);
                SHIFT_ROR: val2 = rm_rot_s[31:0];
                default:   val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand generation, ALU with NZCV flags, status register,
// branch target adder and the EXE/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [3:0]  EXE_CMD,
    input  logic        S,
    input  logic        B,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic        WB_EN,
    input  logic        imm,
    input  logic [11:0] Shift_operand,
    input  logic [23:0] Signed_imm_24,
    input  logic [3:0]  Dest,
    input  logic [31:0] PC,
    input  logic [31:0] Val_Rn,
    input  logic [31:0] Val_Rm,
    output logic [3:0]  SR,
    output logic        Br_taken,
    output logic [31:0] Br_addr,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic        MEM_W_EN_out,
    output logic [31:0] ALU_Res,
    output logic [31:0] Val_Rm_out,
    output logic [3:0]  Dest_out
);

    logic [31:0] val2_s;
    logic [32:0] sum_s;
    logic [31:0] res_s;
    logic        c_s;
    logic        v_s;
    logic [3:0]  flags_s;
    logic [3:0]  sr_r;
    logic        wb_en_r;
    logic        mem_r_en_r;
    logic        mem_w_en_r;
    logic [31:0] alu_res_r;
    logic [31:0] val_rm_r;
    logic [3:0]  dest_r;

    val2_generator u_val2 (
        .mem_en        (MEM_R_EN | MEM_W_EN),
        .imm           (imm),
        .shift_operand (Shift_operand),
        .val_rm        (Val_Rm),
        .val2          (val2_s)
    );

    // ALU; subtraction is Rn + ~Val2 + carry-in so C comes out as NOT borrow
    always_comb begin
        sum_s = 33'd0;
        res_s = 32'd0;
        c_s   = sr_r[SR_C];
        v_s   = sr_r[SR_V];
        case (exe_cmd_e'(EXE_CMD))
            CMD_MOV: res_s = val2_s;
            CMD_MVN: res_s = ~val2_s;
            CMD_ADD, CMD_ADC: begin
                sum_s = {1'b0, Val_Rn} + {1'b0, val2_s}
                      + {32'd0, (EXE_CMD == CMD_ADC) & sr_r[SR_C]};
                res_s = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (Val_Rn[31] == val2_s[31]) && (res_s[31] != Val_Rn[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_s = {1'b0, Val_Rn} + {1'b0, ~val2_s}
                      + {32'd0, (EXE_CMD == CMD_SUB) | sr_r[SR_C]};
                res_s = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (Val_Rn[31] != val2_s[31]) && (res_s[31] != Val_Rn[31]);
            end
            CMD_AND: res_s = Val_Rn & val2_s;
            CMD_ORR: res_s = Val_Rn | val2_s;
            CMD_EOR: res_s = Val_Rn ^ val2_s;
            default: res_s = 32'd0;
        endcase
        flags_s = {res_s[31], (res_s == 32'd0), c_s, v_s};
    end

    // Status register: freeze has priority over S
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_r <= 4'd0;
        end else if (S && !freeze) begin
            sr_r <= flags_s;
        end else begin
            sr_r <= sr_r;
        end
    end

    // EXE/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_r    <= 1'b0;
            mem_r_en_r <= 1'b0;
            mem_w_en_r <= 1'b0;
            alu_res_r  <= 32'd0;
            val_rm_r   <= 32'd0;
            dest_r     <= 4'd0;
        end else if (!freeze) begin
            wb_en_r    <= WB_EN;
            mem_r_en_r <= MEM_R_EN;
            mem_w_en_r <= MEM_W_EN;
            alu_res_r  <= res_s;
            val_rm_r   <= Val_Rm;
            dest_r     <= Dest;
        end else begin
            wb_en_r    <= wb_en_r;
            mem_r_en_r <= mem_r_en_r;
            mem_w_en_r <= mem_w_en_r;
            alu_res_r  <= alu_res_r;
            val_rm_r   <= val_rm_r;
            dest_r     <= dest_r;
        end
    end

    assign Br_taken     = B;
    assign Br_addr      = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign SR           = sr_r;
    assign WB_EN_out    = wb_en_r;
    assign MEM_R_EN_out = mem_r_en_r;
    assign MEM_W_EN_out = mem_w_en_r;
    assign ALU_Res      = alu_res_r;
    assign Val_Rm_out   = val_rm_r;
    assign Dest_out     = dest_r;

endmodule

// File: tb/tb_exe_stage.sv
// Directed plus randomized bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze, S, B, MEM_R_EN, MEM_W_EN, WB_EN, imm;
    logic [3:0]  EXE_CMD, Dest;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic [3:0]  SR, Dest_out;
    logic        Br_taken, WB_EN_out, MEM_R_EN_out, MEM_W_EN_out;
    logic [31:0] Br_addr, ALU_Res, Val_Rm_out;

    int total = 0;
    int bad   = 0;

    logic [3:0]  m_sr;
    logic        m_wb, m_mr, m_mw;
    logic [31:0] m_res, m_rm;
    logic [3:0]  m_dest;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .EXE_CMD(EXE_CMD), .S(S), .B(B),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24), .Dest(Dest),
        .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .SR(SR), .Br_taken(Br_taken),
        .Br_addr(Br_addr), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .MEM_W_EN_out(MEM_W_EN_out), .ALU_Res(ALU_Res), .Val_Rm_out(Val_Rm_out),
        .Dest_out(Dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand 2 built bit by bit, one rotate/shift step at a time
    function automatic logic [31:0] ref_val2(input logic mem, input logic im,
                                             input logic [11:0] so, input logic [31:0] rm);
        logic [31:0] v;
        int n;
        if (mem) return {20'd0, so};
        if (im) begin
            v = {24'd0, so[7:0]};
            n = 2 * int'(so[11:8]);
            for (int i = 0; i < n; i++) v = {v[0], v[31:1]};
            return v;
        end
        v = rm;
        n = int'(so[11:7]);
        for (int i = 0; i < n; i++) begin
            case (so[6:5])
                2'b00:   v = {v[30:0], 1'b0};
                2'b01:   v = {1'b0, v[31:1]};
                2'b10:   v = {v[31], v[31:1]};
                default: v = {v[0], v[31:1]};
            endcase
        end
        return v;
    endfunction

    // ALU in 64-bit integer arithmetic; carry and overflow from range tests
    task automatic ref_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                           input logic [3:0] sr, output logic [31:0] res, output logic [3:0] fl);
        longint ua, ub, sa, sb, u, s, cin;
        logic c, v;
        ua = longint'(rn);
        ub = longint'(v2);
        sa = longint'($signed(rn));
        sb = longint'($signed(v2));
        cin = sr[1] ? 64'sd1 : 64'sd0;
        c = sr[1];
        v = sr[0];
        res = 32'd0;
        case (cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd2, 4'd3: begin
                u = ua + ub + ((cmd == 4'd3) ? cin : 64'sd0);
                s = sa + sb + ((cmd == 4'd3) ? cin : 64'sd0);
                res = u[31:0];
                c = (u > 64'sd4294967295);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5: begin
                u = ua - ub - ((cmd == 4'd5) ? (64'sd1 - cin) : 64'sd0);
                s = sa - sb - ((cmd == 4'd5) ? (64'sd1 - cin) : 64'sd0);
                res = u[31:0];
                c = (u >= 64'sd0);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            default: res = 32'd0;
        endcase
        fl = {res[31], res == 32'd0, c, v};
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".sr"},      32'(SR),           32'(m_sr));
        chk({tag, ".wb"},      32'(WB_EN_out),    32'(m_wb));
        chk({tag, ".mr"},      32'(MEM_R_EN_out), 32'(m_mr));
        chk({tag, ".mw"},      32'(MEM_W_EN_out), 32'(m_mw));
        chk({tag, ".alu_res"}, ALU_Res,           m_res);
        chk({tag, ".val_rm"},  Val_Rm_out,        m_rm);
        chk({tag, ".dest"},    32'(Dest_out),     32'(m_dest));
    endtask

    task automatic model_reset();
        m_sr = 4'd0; m_wb = 1'b0; m_mr = 1'b0; m_mw = 1'b0;
        m_res = 32'd0; m_rm = 32'd0; m_dest = 4'd0;
    endtask

    task automatic clear_inputs();
        freeze = 1'b0; EXE_CMD = 4'd0; S = 1'b0; B = 1'b0; MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0; WB_EN = 1'b0; imm = 1'b0; Shift_operand = 12'd0;
        Signed_imm_24 = 24'd0; Dest = 4'd0; PC = 32'd0; Val_Rn = 32'd0; Val_Rm = 32'd0;
    endtask

    // Called just after a falling edge with inputs applied; ends on the next falling edge
    task automatic step(input string tag);
        logic [31:0] v2, res;
        logic [3:0]  fl;
        longint off;
        v2 = ref_val2(MEM_R_EN | MEM_W_EN, imm, Shift_operand, Val_Rm);
        ref_alu(EXE_CMD, Val_Rn, v2, m_sr, res, fl);
        off = longint'($signed(Signed_imm_24)) * 64'sd4;
        #1;
        chk({tag, ".br_taken"}, 32'(Br_taken), 32'(B));
        chk({tag, ".br_addr"},  Br_addr, 32'(longint'(PC) + off));
        @(posedge clk);
        if (!freeze) begin
            m_wb = WB_EN; m_mr = MEM_R_EN; m_mw = MEM_W_EN;
            m_res = res; m_rm = Val_Rm; m_dest = Dest;
        end
        if (S && !freeze) m_sr = fl;
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        check_regs("reset");
        rst = 1'b0;

        // 0x7FFFFFFF + 1 with flags
        EXE_CMD = 4'd2; S = 1'b1; imm = 1'b1; Shift_operand = 12'h001;
        Val_Rn = 32'h7FFF_FFFF; WB_EN = 1'b1; Dest = 4'd3;
        step("add_ovf");
        chk("add_ovf.res_const", ALU_Res, 32'h8000_0000);
        chk("add_ovf.sr_const", 32'(SR), 32'h9);

        // 5 - 5, then SBC 7 - 3 with C set
        EXE_CMD = 4'd4; Val_Rn = 32'd5; Shift_operand = 12'h005;
        step("sub_zero");
        chk("sub_zero.sr_const", 32'(SR), 32'h6);
        EXE_CMD = 4'd5; Val_Rn = 32'd7; Shift_operand = 12'h003;
        step("sbc");
        chk("sbc.res_const", ALU_Res, 32'd4);

        // Rotated immediate and register ASR through MOV
        EXE_CMD = 4'd1; S = 1'b0; Shift_operand = 12'h4FF;
        step("mov_imm");
        chk("mov_imm.res_const", ALU_Res, 32'hFF00_0000);
        imm = 1'b0; Val_Rm = 32'h8000_0000; Shift_operand = 12'h240;
        step("mov_asr");
        chk("mov_asr.res_const", ALU_Res, 32'hF800_0000);

        // Branch target
        B = 1'b1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_const.taken", 32'(Br_taken), 32'd1);
        chk("br_const.addr", Br_addr, 32'h0F8);
        step("branch");

        // Three frozen S=1 ops, then resume
        B = 1'b0; imm = 1'b1; S = 1'b1; EXE_CMD = 4'd2;
        Val_Rn = 32'h1234; Shift_operand = 12'h010; MEM_R_EN = 1'b1;
        step("pre_freeze");
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            EXE_CMD = 4'd4; Val_Rn = $urandom; Val_Rm = $urandom; Dest = 4'(i + 5);
            MEM_R_EN = 1'b0; WB_EN = 1'b0; Shift_operand = 12'(i);
            step("frozen");
        end
        freeze = 1'b0;
        step("resume");

        // Reset between edges while frozen
        freeze = 1'b1; EXE_CMD = 4'd8; Val_Rn = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("rst_mid_freeze");
        @(negedge clk);
        rst = 1'b0;
        freeze = 1'b0;
        step("after_rst");

        // Randomized traffic including bubbles and stalls
        for (int i = 0; i < 400; i++) begin
            freeze = ($urandom_range(0, 3) == 0);
            EXE_CMD = 4'($urandom_range(0, 15));
            S = 1'($urandom); B = 1'($urandom); imm = 1'($urandom);
            MEM_R_EN = ($urandom_range(0, 5) == 0);
            MEM_W_EN = ($urandom_range(0, 5) == 0);
            WB_EN = 1'($urandom);
            Shift_operand = 12'($urandom); Signed_imm_24 = 24'($urandom);
            Dest = 4'($urandom); PC = $urandom;
            Val_Rn = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
            Val_Rm = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                EXE_CMD = 4'd0; S = 1'b0; B = 1'b0; MEM_R_EN = 1'b0;
                MEM_W_EN = 1'b0; WB_EN = 1'b0;
            end
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
